// File: rtl/display_sequencer.sv
// display_sequencer: frame-periodic arbiter. It time-multiplexes NCH drawing
// engines onto one registered pixel write port that feeds the frame buffer.
// Each frame, the enabled engines are granted in index order. A grant ends
// when the engine pulses done or when its cycle budget runs out.
// Optional feature macro: DISPLAY_SEQ_OVERRUN_EN adds the overrun_cnt output.
module display_sequencer #(
  parameter int NCH          = 4,
  parameter int XW           = 8,
  parameter int YW           = 8,
  parameter int CW           = 12,
  parameter int FRAME_CYCLES = 500000,
  parameter int BW           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    chan_en,
  input  logic [NCH*BW-1:0] budget,
  input  logic [NCH*XW-1:0] eng_x,
  input  logic [NCH*YW-1:0] eng_y,
  input  logic [NCH*CW-1:0] eng_color,
  input  logic [NCH-1:0]    eng_we,
  input  logic [NCH-1:0]    eng_done,
  output logic [NCH-1:0]    lock,
  output logic [XW-1:0]     CounterX,
  output logic [YW-1:0]     CounterY,
  output logic [CW-1:0]     color,
  output logic              we,
  output logic [2:0]        cur_ch,
  output logic              frame_start,
  output logic [NCH-1:0]    timeout
`ifdef DISPLAY_SEQ_OVERRUN_EN
  , output logic [7:0]      overrun_cnt
`endif
);

  typedef enum logic [1:0] {WAIT_FRAME, SELECT, GRANT} state_t;

  state_t         r_state;
  logic [BW-1:0]  r_fcnt, r_bcnt;
  logic [NCH-1:0] r_en_q, r_lock, r_timeout;
  logic [2:0]     r_ch, r_cur_ch;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [CW-1:0]  r_color;
  logic           r_we;

  logic           w_fs, w_last;
  logic           w_sel_en, w_sel_we, w_sel_done;
  logic [BW-1:0]  w_sel_bud;
  logic [XW-1:0]  w_sel_x;
  logic [YW-1:0]  w_sel_y;
  logic [CW-1:0]  w_sel_color;
  logic [NCH-1:0] w_onehot;

  // Free-running frame counter, 0..FRAME_CYCLES-1
  always_ff @(posedge clk) begin
    if (rst)                                   r_fcnt <= '0;
    else if (r_fcnt == BW'(FRAME_CYCLES - 1))  r_fcnt <= '0;
    else                                       r_fcnt <= r_fcnt + BW'(1);
  end

  // Held low during reset so that "all outputs 0" holds; the first pulse follows release
  assign w_fs   = ~rst & (r_fcnt == '0);
  assign w_last = (r_ch == 3'(NCH - 1));

  // Mux the fields of the engine at the current index (loop form keeps index widths exact)
  always_comb begin
    w_sel_en    = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_done  = 1'b0;
    w_sel_bud   = '0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_color = '0;
    w_onehot    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == i[2:0]) begin
        w_sel_en    = r_en_q[i];
        w_sel_we    = eng_we[i];
        w_sel_done  = eng_done[i];
        w_sel_bud   = budget[i*BW +: BW];
        w_sel_x     = eng_x[i*XW +: XW];
        w_sel_y     = eng_y[i*YW +: YW];
        w_sel_color = eng_color[i*CW +: CW];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Grant FSM plus registered pixel path; any grant drop forces we low next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_FRAME;
      r_en_q    <= '0;
      r_lock    <= '0;
      r_timeout <= '0;
      r_ch      <= '0;
      r_cur_ch  <= '0;
      r_bcnt    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
      r_we      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        WAIT_FRAME: begin
          if (w_fs) begin
            r_en_q  <= chan_en;
            r_ch    <= '0;
            r_state <= SELECT;
          end
        end
        SELECT: begin
          if (w_fs) begin
            r_en_q <= chan_en;
            r_ch   <= '0;
          end else if (w_sel_en && (w_sel_bud != '0)) begin
            r_lock   <= w_onehot;
            r_cur_ch <= r_ch;
            r_bcnt   <= w_sel_bud;
            r_state  <= GRANT;
          end else if (w_last) begin
            r_state <= WAIT_FRAME;
          end else begin
            r_ch <= r_ch + 3'd1;
          end
        end
        GRANT: begin
          if (w_fs) begin
            // Frame overrun: abandon this grant and restart the frame, no timeout
            r_lock   <= '0;
            r_cur_ch <= '0;
            r_en_q   <= chan_en;
            r_ch     <= '0;
            r_state  <= SELECT;
          end else if (w_sel_done || (r_bcnt == BW'(1))) begin
            // Done wins over a simultaneous expiry
            if (!w_sel_done) r_timeout <= r_timeout | w_onehot;
            r_lock   <= '0;
            r_cur_ch <= '0;
            if (w_last) r_state <= WAIT_FRAME;
            else begin
              r_ch    <= r_ch + 3'd1;
              r_state <= SELECT;
            end
          end else begin
            r_bcnt  <= r_bcnt - BW'(1);
            r_x     <= w_sel_x;
            r_y     <= w_sel_y;
            r_color <= w_sel_color;
            r_we    <= w_sel_we;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

`ifdef DISPLAY_SEQ_OVERRUN_EN
  logic [7:0] r_overrun;
  // Saturating count of frame starts that arrive before the sequence finished
  always_ff @(posedge clk) begin
    if (rst) r_overrun <= '0;
    else if (w_fs && (r_state != WAIT_FRAME) && (r_overrun != 8'hFF))
      r_overrun <= r_overrun + 8'd1;
  end
  assign overrun_cnt = r_overrun;
`endif

  assign lock        = r_lock;
  assign CounterX    = r_x;
  assign CounterY    = r_y;
  assign color       = r_color;
  assign we          = r_we;
  assign cur_ch      = r_cur_ch;
  assign frame_start = w_fs;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: NCH=2, 64-cycle frames.
module tb_display_sequencer;
  localparam int NCH = 2, XW = 8, YW = 8, CW = 12, FC = 64, BW = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    chan_en, eng_we, eng_done, lock, timeout;
  logic [NCH*BW-1:0] budget;
  logic [NCH*XW-1:0] eng_x;
  logic [NCH*YW-1:0] eng_y;
  logic [NCH*CW-1:0] eng_color;
  logic [XW-1:0]     CounterX;
  logic [YW-1:0]     CounterY;
  logic [CW-1:0]     color;
  logic              we, frame_start;
  logic [2:0]        cur_ch;
`ifdef DISPLAY_SEQ_OVERRUN_EN
  logic [7:0]        overrun_cnt;
`endif

  display_sequencer #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .FRAME_CYCLES(FC), .BW(BW)) dut (
    .clk(clk), .rst(rst), .chan_en(chan_en), .budget(budget), .eng_x(eng_x), .eng_y(eng_y),
    .eng_color(eng_color), .eng_we(eng_we), .eng_done(eng_done), .lock(lock),
    .CounterX(CounterX), .CounterY(CounterY), .color(color), .we(we), .cur_ch(cur_ch),
    .frame_start(frame_start), .timeout(timeout)
`ifdef DISPLAY_SEQ_OVERRUN_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 200; i++) begin
      if (frame_start) break;
      tick();
    end
    chk("frame_start_wait", 32'(frame_start), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; chan_en = '0; budget = '0; eng_x = '0; eng_y = '0;
    eng_color = '0; eng_we = '0; eng_done = '0;

    // 1: reset state, first frame_start right after release
    repeat (3) tick();
    chk("rst_lock", 32'(lock), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_x", 32'(CounterX), 0);
    chk("rst_y", 32'(CounterY), 0);
    chk("rst_color", 32'(color), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cur_ch", 32'(cur_ch), 0);
    chk("rst_fs", 32'(frame_start), 0);
    rst = 1'b0;
    #1;
    chk("fs_after_rst", 32'(frame_start), 1);
    tick();
    chk("fs_pulse_low", 32'(frame_start), 0);

    // 2 + 5: two engines, done at 10 and 20, data path and we forcing
    wait_fs();
    chan_en = 2'b11; budget = {20'd50, 20'd100};
    tick();
    chk("t2_select", 32'(lock), 0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      chk("t2_lock0", 32'(lock), 2'b01);
      if (k == 2) begin
        eng_x = {8'h77, 8'h3C}; eng_y = {8'h66, 8'h5A};
        eng_color = {12'h999, 12'hABC}; eng_we = 2'b11;
      end
      if (k == 3) begin
        chk("t5_x", 32'(CounterX), 8'h3C);
        chk("t5_y", 32'(CounterY), 8'h5A);
        chk("t5_color", 32'(color), 12'hABC);
        chk("t5_we", 32'(we), 1);
        chk("t5_cur_ch0", 32'(cur_ch), 0);
        eng_we = 2'b10;
      end
      if (k == 4) begin
        chk("t5_we_other", 32'(we), 0);
        chk("t5_x_hold", 32'(CounterX), 8'h3C);
        eng_we = 2'b00;
      end
      if (k == 9) eng_we = 2'b01;
      if (k == 10) begin
        chk("t2_we_last", 32'(we), 1);
        eng_done = 2'b01;
      end
      tick();
    end
    eng_done = '0; eng_we = '0;
    chk("t2_gap", 32'(lock), 0);
    chk("t2_we_forced", 32'(we), 0);
    chk("t2_gap_cur_ch", 32'(cur_ch), 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      chk("t2_lock1", 32'(lock), 2'b10);
      if (k == 1) chk("t2_cur_ch1", 32'(cur_ch), 1);
      if (k == 2) chk("t2_x_ch1", 32'(CounterX), 8'h77);
      if (k == 20) eng_done = 2'b10;
      tick();
    end
    eng_done = '0;
    chk("t2_end", 32'(lock), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_idle", 32'(lock), 0);
    end
    chk("t2_timeout", 32'(timeout), 0);

    // 3: budget 5, never done -> exactly 5 cycles, sticky timeout
    wait_fs();
    chan_en = 2'b01; budget = {20'd0, 20'd5};
    tick();
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk("t3_lock", 32'(lock), 2'b01);
      if (k == 5) chk("t3_timeout_pre", 32'(timeout), 0);
      tick();
    end
    chk("t3_drop", 32'(lock), 0);
    chk("t3_timeout", 32'(timeout), 2'b01);
    wait_fs();
    chk("t3_sticky", 32'(timeout), 2'b01);
    tick();
    tick();
    chk("t3_regrant", 32'(lock), 2'b01);
    tick();
    chk("t3_regrant2", 32'(lock), 2'b01);
    // reset in the middle of a grant
    rst = 1'b1;
    tick();
    chk("rst_mid_lock", 32'(lock), 0);
    chk("rst_mid_timeout", 32'(timeout), 0);
    chk("rst_mid_cur_ch", 32'(cur_ch), 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_fs", 32'(frame_start), 1);

    // 4: done on the last budget cycle, zero budget skips engine 1
    chan_en = 2'b11; budget = {20'd0, 20'd8};
    tick();
    chk("t4_select", 32'(lock), 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("t4_lock", 32'(lock), 2'b01);
      if (k == 8) eng_done = 2'b01;
      tick();
    end
    eng_done = '0;
    chk("t4_drop", 32'(lock), 0);
    chk("t4_timeout", 32'(timeout), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_skip1", 32'(lock), 0);
    end

    // 6: grant longer than the frame -> abort at count 0 and re-lock
    wait_fs();
    chan_en = 2'b01; budget = {20'd0, 20'd100};
    tick();
    tick();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (lock != 2'b01) break;
      n++;
      tick();
    end
    chk("t6_len1", 32'(n), 63);
    chk("t6_abort", 32'(lock), 0);
    chk("t6_timeout", 32'(timeout), 0);
`ifdef DISPLAY_SEQ_OVERRUN_EN
    chk("t6_ovr1", 32'(overrun_cnt), 1);
`endif
    tick();
    chk("t6_relock", 32'(lock), 2'b01);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (lock != 2'b01) break;
      n++;
      tick();
    end
    chk("t6_len2", 32'(n), 63);
    chk("t6_timeout2", 32'(timeout), 0);
`ifdef DISPLAY_SEQ_OVERRUN_EN
    chk("t6_ovr2", 32'(overrun_cnt), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
